// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one 4-bit ripple-carry adder reused across NIBBLES cycles.
// Optional two's-complement overflow output is enabled with the ADDER_OVF_EN macro.

module ripplecarry (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c0_i,
  output logic [3:0] s_o,
  output logic       c4_o
);
  logic [4:0] c;

  always_comb begin
    c[0] = c0_i;
    s_o  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c4_o = c[4];
  end
endmodule

module serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
`ifdef ADDER_OVF_EN
  output logic                   ovf,
`endif
  output logic                   cout
);
  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [IDX_W+1:0] bit_lo;
  logic [3:0]       add_a, add_b, add_s;
  logic             add_c4;

  assign bit_lo = {idx_q, 2'b00};
  assign add_a  = a_q[bit_lo +: 4];
  assign add_b  = b_q[bit_lo +: 4];

  ripplecarry u_rca (
    .a_i  (add_a),
    .b_i  (add_b),
    .c0_i (carry_q),
    .s_o  (add_s),
    .c4_o (add_c4)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[bit_lo +: 4] = add_s;
        carry_d            = add_c4;
        idx_d              = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_LAST) begin
          cout_d  = add_c4;
          // Carry into the MSB recovered from the operand bits and its sum bit
          ovf_d   = (a_q[W-1] ^ b_q[W-1] ^ add_s[3]) ^ add_c4;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef ADDER_OVF_EN
  assign ovf  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random self-checking bench for serial_add_ctrl (NIBBLES=4).
// Overflow checks are compiled in when ADDER_OVF_EN is defined.

module tb_serial_add_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

`ifndef ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  // Launch one operation; returns start-to-done edges, busy cycle count, overlap flag and results
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       output int lat, output int nbusy, output logic both,
                       output logic [W-1:0] s, output logic co, output logic ov);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0; nbusy = 0; both = 1'b0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy && done) both = 1'b1;
    s = sum; co = cout; ov = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, cout, ovf, sum} !== {4'b0000, 16'h0000}) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0", busy, done, cout, ovf, sum);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL first_start_after_reset: busy=%b want 1", busy);
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if ({sum, cout} !== {16'hFFFF, 1'b1}) begin
      bad++;
      $display("FAIL reset_then_op: sum=%h cout=%b want ffff 1", sum, cout);
    end
  endtask

  task automatic test_basic();
    int lat, nb; logic both, co, ov; logic [W-1:0] s;
    do_op(16'h1234, 16'h4321, 1'b0, lat, nb, both, s, co, ov);
    total++;
    if ({s, co} !== {16'h5555, 1'b0}) begin
      bad++; $display("FAIL basic_sum: sum=%h cout=%b want 5555 0", s, co);
    end
    total++;
    if (lat !== 4 || nb !== 4) begin
      bad++; $display("FAIL basic_latency: lat=%0d busy_cycles=%0d want 4 4", lat, nb);
    end
    total++;
    if (both !== 1'b0) begin
      bad++; $display("FAIL busy_done_overlap: both=%b want 0", both);
    end
`ifdef ADDER_OVF_EN
    total++;
    if (ov !== 1'b0) begin
      bad++; $display("FAIL ovf_1234_4321: ovf=%b want 0", ov);
    end
`endif
  endtask

  task automatic test_carry_chain();
    int lat, nb; logic both, co, ov; logic [W-1:0] s;
    do_op(16'hFFFF, 16'h0001, 1'b0, lat, nb, both, s, co, ov);
    total++;
    if ({s, co} !== {16'h0000, 1'b1}) begin
      bad++; $display("FAIL carry_b1: sum=%h cout=%b want 0000 1", s, co);
    end
    do_op(16'hFFFF, 16'h0000, 1'b1, lat, nb, both, s, co, ov);
    total++;
    if ({s, co} !== {16'h0000, 1'b1}) begin
      bad++; $display("FAIL carry_cin: sum=%h cout=%b want 0000 1", s, co);
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, lat, nb, both, s, co, ov);
    total++;
    if ({s, co} !== {16'h1000, 1'b0}) begin
      bad++; $display("FAIL carry_mid: sum=%h cout=%b want 1000 0", s, co);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h1111;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({done, busy, sum, cout} !== {2'b10, 16'h1010, 1'b0}) begin
      bad++; $display("FAIL ignore_start_result: done=%b busy=%b sum=%h cout=%b want 1 0 1010 0", done, busy, sum, cout);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (8) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    total++;
    if (dones !== 0 || sum !== 16'h1010) begin
      bad++; $display("FAIL no_second_op: active_cycles=%0d sum=%h want 0 1010", dones, sum);
    end
  endtask

  task automatic test_reset_abort();
    int dones, lat, nb; logic both, co, ov; logic [W-1:0] s;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy, done, sum, cout} !== {2'b00, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL abort_state: busy=%b done=%b sum=%h cout=%b want 0 0 0000 0", busy, done, sum, cout);
    end
    dones = 0;
    repeat (8) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL abort_no_done: active_cycles=%0d want 0", dones);
    end
    do_op(16'h00FF, 16'h0001, 1'b1, lat, nb, both, s, co, ov);
    total++;
    if ({s, co} !== {16'h0101, 1'b0} || lat !== 4) begin
      bad++; $display("FAIL after_abort: sum=%h cout=%b lat=%0d want 0101 0 4", s, co, lat);
    end
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    int lat, nb; logic both, co, ov; logic [W-1:0] s;
    do_op(16'h7FFF, 16'h0001, 1'b0, lat, nb, both, s, co, ov);
    total++;
    if ({s, ov, co} !== {16'h8000, 2'b10}) begin
      bad++; $display("FAIL ovf_pos: sum=%h ovf=%b cout=%b want 8000 1 0", s, ov, co);
    end
    do_op(16'h8000, 16'h8000, 1'b0, lat, nb, both, s, co, ov);
    total++;
    if ({s, ov, co} !== {16'h0000, 2'b11}) begin
      bad++; $display("FAIL ovf_neg: sum=%h ovf=%b cout=%b want 0000 1 1", s, ov, co);
    end
  endtask
`endif

  task automatic test_random();
    int lat, nb, errs, lat_errs; logic both, co, ov, ci; logic [W-1:0] s, av, bv;
    logic [W:0] ref_v;
    errs = 0; lat_errs = 0;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom); bv = W'($urandom); ci = 1'($urandom);
      ref_v = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(av, bv, ci, lat, nb, both, s, co, ov);
      if ({co, s} !== ref_v) begin
        errs++;
        if (errs <= 5) $display("FAIL random_sum: a=%h b=%h cin=%b got %b_%h want %h", av, bv, ci, co, s, ref_v);
      end
      if (lat !== 4 || nb !== 4 || both) lat_errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL random_sum_total: errors=%0d want 0", errs);
    end
    total++;
    if (lat_errs !== 0) begin
      bad++; $display("FAIL random_latency: errors=%0d want 0", lat_errs);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_ignore_start();
    test_reset_abort();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
